branch_predictor_bht: RTL and testbench

- Parametrised successor to the single-entry predictor used in the decode stage.
- Indexed pattern history table (PHT) of saturating counters.
- Resolves JAL/JALR targets; corrects mispredicts reported by EX.
- Counts mispredicts.
- Sits in ID: lookup for the instruction in IF/ID, update from the branch resolved in EX one cycle later.

---
 rtl/bp_pkg.sv | 27 ++
 rtl/sat_counter_table.sv | 46 ++++
 rtl/branch_predictor_bht.sv | 122 ++++++++++++
 tb/tb_branch_predictor_bht.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the ID-stage branch predictor.
// Counter init/max helpers and the EX->ID update bundle.
package bp_pkg;

  localparam int BP_XLEN  = 32;
  localparam int BP_IDX_W = 6;

  function automatic int cnt_init(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  typedef logic [BP_IDX_W-1:0] pht_idx_t;

  typedef struct packed {
    logic               valid;
    pht_idx_t           idx;
    logic               predict;
    logic               actual;
    logic [BP_XLEN-1:0] pc;
    logic [BP_XLEN-1:0] target;
  } bp_upd_t;

endpackage

// File: rtl/sat_counter_table.sv
// Pattern history table: one saturating counter per entry.
// Reads are combinational; writes land on the clock edge.
module sat_counter_table
  import bp_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] pht [DEPTH];
  logic [CNT_W-1:0] cur;
  logic [CNT_W-1:0] nxt;

  assign rd_taken = pht[rd_idx][CNT_W-1];
  assign cur      = pht[wr_idx];

  always_comb begin
    nxt = cur;
    if (wr_taken) begin
      if (cur != CNT_MAX) nxt = cur + 1'b1;
    end else begin
      if (cur != '0) nxt = cur - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pht[i] <= CNT_INIT;
    end else if (wr_en) begin
      pht[wr_idx] <= nxt;
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// ID-stage bimodal branch predictor with jump target resolution.
// Define BP_GSHARE_EN to XOR global history into the PHT index.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int XLEN   = BP_XLEN,
  parameter int IDX_W  = BP_IDX_W,
  parameter int CNT_W  = 2,
  parameter int GHR_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch,
  input  logic              ujtype,
  input  logic              jalr,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   target_pc,
  output logic              predict_result,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_predict,
  input  logic              upd_actual,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic [XLEN-1:0]   upd_target,
  output logic              predict_fail,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [PERF_W-1:0] miss_count
);

  bp_upd_t          upd;
  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] idx;
  logic             pht_taken;
  logic [XLEN-1:0]  seq_pc;
  logic [XLEN-1:0]  br_pc;
  logic [XLEN-1:0]  jr_pc;

  assign upd = '{
    valid:   upd_valid,
    idx:     upd_idx,
    predict: upd_predict,
    actual:  upd_actual,
    pc:      upd_pc,
    target:  upd_target
  };

  assign pc_idx = pc[IDX_W+1:2];

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  // History follows resolved outcomes only, never speculative ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr <= '0;
    end else if (upd.valid) begin
      ghr <= GHR_W'({ghr, upd.actual});
    end
  end

  assign idx = pc_idx ^ IDX_W'(ghr);
`else
  assign idx = pc_idx;
`endif

  assign pred_idx = idx;

  sat_counter_table #(
    .IDX_W(IDX_W),
    .CNT_W(CNT_W)
  ) u_pht (
    .clk     (clk),
    .rst_n   (rst),
    .rd_idx  (idx),
    .rd_taken(pht_taken),
    .wr_en   (upd.valid),
    .wr_idx  (upd.idx),
    .wr_taken(upd.actual)
  );

  assign seq_pc = pc + XLEN'(4);
  assign br_pc  = pc + imm;
  assign jr_pc  = (rs1_data + imm) & ~XLEN'(1);

  always_comb begin
    predict_result = 1'b0;
    target_pc      = seq_pc;
    if (rst) begin
      unique case (1'b1)
        ujtype && !jalr: begin
          predict_result = 1'b1;
          target_pc      = br_pc;
        end
        ujtype && jalr: begin
          predict_result = 1'b1;
          target_pc      = jr_pc;
        end
        branch && !ujtype: begin
          predict_result = pht_taken;
          target_pc      = pht_taken ? br_pc : seq_pc;
        end
        default: ;
      endcase
    end
  end

  assign predict_fail = rst & upd.valid & (upd.predict ^ upd.actual);
  assign redirect_pc  = upd.actual ? upd.target : upd.pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_count <= '0;
    end else if (predict_fail && (miss_count != '1)) begin
      miss_count <= miss_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht.
// Build with +define+BP_GSHARE_EN to exercise the gshare path.
module tb_branch_predictor_bht;

  typedef struct packed {
    logic [31:0] tpc;
    logic        pr;
    logic [5:0]  pidx;
    logic        pf;
    logic [31:0] rpc;
    logic [31:0] mc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch, ujtype, jalr;
  logic [31:0] pc, imm, rs1_data;
  logic [31:0] target_pc;
  logic        predict_result;
  logic [5:0]  pred_idx;
  logic        upd_valid;
  logic [5:0]  upd_idx;
  logic        upd_predict, upd_actual;
  logic [31:0] upd_pc, upd_target;
  logic        predict_fail;
  logic [31:0] redirect_pc;
  logic [31:0] miss_count;

  int checks = 0;
  int failures = 0;

  exp_t  expq [$];
  exp_t  obsq [$];
  string nmq  [$];
  exp_t  obs;

  int          m_cnt [64];
  logic [31:0] m_miss;
  logic [5:0]  m_ghr;

  branch_predictor_bht dut (
    .clk           (clk),
    .rst           (rst),
    .branch        (branch),
    .ujtype        (ujtype),
    .jalr          (jalr),
    .pc            (pc),
    .imm           (imm),
    .rs1_data      (rs1_data),
    .target_pc     (target_pc),
    .predict_result(predict_result),
    .pred_idx      (pred_idx),
    .upd_valid     (upd_valid),
    .upd_idx       (upd_idx),
    .upd_predict   (upd_predict),
    .upd_actual    (upd_actual),
    .upd_pc        (upd_pc),
    .upd_target    (upd_target),
    .predict_fail  (predict_fail),
    .redirect_pc   (redirect_pc),
    .miss_count    (miss_count)
  );

  always #5 clk = ~clk;

  assign obs = {target_pc, predict_result, pred_idx,
                predict_fail, redirect_pc, miss_count};

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_cnt[i] = 1;
    m_miss = 0;
    m_ghr  = 0;
  endfunction

  function automatic exp_t model();
    exp_t e;
    logic [5:0] i;
    i = pc[7:2];
`ifdef BP_GSHARE_EN
    i = i ^ m_ghr;
`endif
    e.pidx = i;
    e.mc   = m_miss;
    e.rpc  = upd_actual ? upd_target : upd_pc + 32'd4;
    e.pf   = rst && upd_valid && (upd_predict != upd_actual);
    e.pr   = 1'b0;
    e.tpc  = pc + 32'd4;
    if (rst) begin
      if (ujtype && !jalr) begin
        e.pr  = 1'b1;
        e.tpc = pc + imm;
      end else if (ujtype) begin
        e.pr  = 1'b1;
        e.tpc = (rs1_data + imm) & 32'hFFFF_FFFE;
      end else if (branch) begin
        e.pr  = (m_cnt[i] >= 2);
        e.tpc = e.pr ? pc + imm : pc + 32'd4;
      end
    end
    return e;
  endfunction

  function automatic void model_commit();
    if (rst && upd_valid) begin
      if (upd_actual && m_cnt[upd_idx] < 3) m_cnt[upd_idx]++;
      if (!upd_actual && m_cnt[upd_idx] > 0) m_cnt[upd_idx]--;
      if (upd_predict != upd_actual && m_miss != 32'hFFFF_FFFF)
        m_miss = m_miss + 1;
      m_ghr = {m_ghr[4:0], upd_actual};
    end
  endfunction

  task automatic set_lk(input logic b, input logic u, input logic j,
                        input logic [31:0] p, input logic [31:0] im,
                        input logic [31:0] r);
    branch = b; ujtype = u; jalr = j;
    pc = p; imm = im; rs1_data = r;
  endtask

  task automatic set_upd(input logic v, input logic [5:0] ix,
                         input logic p, input logic a,
                         input logic [31:0] upc, input logic [31:0] tg);
    upd_valid = v; upd_idx = ix; upd_predict = p; upd_actual = a;
    upd_pc = upc; upd_target = tg;
  endtask

  task automatic idle();
    set_lk(0, 0, 0, 0, 0, 0);
    set_upd(0, 0, 0, 0, 0, 0);
  endtask

  // Push expectation, capture output mid-cycle, then advance one edge.
  task automatic tick(input string nm, input exp_t e);
    expq.push_back(e);
    nmq.push_back(nm);
    @(negedge clk);
    obsq.push_back(obs);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    string s;
    rst = 1'b0;
    model_reset();
    idle();
    @(posedge clk);
    #1;
    set_lk(1, 0, 0, 32'h100, 32'h20, 0);
    set_upd(1, 0, 0, 1, 0, 32'h200);
    tick("reset_held", '{tpc: 32'h104, pr: 1'b0, pidx: 6'd0, pf: 1'b0,
                         rpc: 32'h200, mc: 32'd0});
    rst = 1'b1;
    set_upd(0, 0, 0, 0, 0, 0);
    tick("reset_release", '{tpc: 32'h104, pr: 1'b0, pidx: 6'd0, pf: 1'b0,
                            rpc: 32'h4, mc: 32'd0});
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); s = nmq.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %p expected %p", s, o, e);
      end
    end
  endtask

  task automatic test_training();
    exp_t e, o;
    string s;
    idle();
    set_upd(1, 0, 1, 1, 0, 32'h80);
    repeat (2) tick("train_up", model());
    idle();
    set_lk(1, 0, 0, 32'h0, 32'h44, 0);
    tick("train_taken", model());
    set_lk(0, 0, 0, 0, 0, 0);
    set_upd(1, 0, 1, 1, 0, 32'h80);
    repeat (9) tick("train_sat_hi", model());
    idle();
    set_lk(1, 0, 0, 32'h0, 32'h44, 0);
    tick("train_after_sat", model());
    set_upd(1, 0, 0, 0, 32'h10, 0);
    tick("train_nt_hazard", model());
    idle();
    set_lk(1, 0, 0, 32'h0, 32'h44, 0);
    tick("train_one_nt", model());
    set_upd(1, 0, 0, 0, 32'h10, 0);
    tick("train_nt2", model());
    set_upd(0, 0, 0, 0, 0, 0);
    tick("train_weak_nt", model());
    idle();
    set_upd(1, 5, 0, 0, 32'h14, 0);
    repeat (3) tick("sat_lo_dn", model());
    set_upd(1, 5, 1, 1, 32'h14, 32'h90);
    tick("sat_lo_up", model());
    idle();
    set_lk(1, 0, 0, 32'h14, 32'h8, 0);
    tick("sat_lo_look1", model());
    set_upd(1, 5, 1, 1, 32'h14, 32'h90);
    tick("sat_lo_up2", model());
    set_upd(0, 0, 0, 0, 0, 0);
    tick("sat_lo_look2", model());
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); s = nmq.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %p expected %p", s, o, e);
      end
    end
  endtask

  task automatic test_mispredict();
    exp_t e, o;
    string s;
    idle();
    set_upd(1, 10, 0, 1, 32'h180, 32'h200);
    tick("miss_nt_to_t", model());
    set_upd(1, 10, 1, 0, 32'h300, 32'h400);
    tick("miss_t_to_nt", model());
    idle();
    tick("miss_count2", model());
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); s = nmq.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %p expected %p", s, o, e);
      end
    end
  endtask

  task automatic test_jumps();
    exp_t e, o;
    string s;
    idle();
    set_lk(0, 1, 0, 32'h40, 32'hFFFF_FFF8, 0);
    tick("jal", '{tpc: 32'h38, pr: 1'b1, pidx: 6'h10, pf: 1'b0,
                  rpc: 32'h4, mc: m_miss});
    set_lk(0, 1, 1, 32'h80, 32'h2, 32'h1001);
    tick("jalr", '{tpc: 32'h1002, pr: 1'b1, pidx: 6'h20, pf: 1'b0,
                   rpc: 32'h4, mc: m_miss});
    set_lk(1, 0, 0, 32'h40, 32'h10, 0);
    tick("jal_pht_same", '{tpc: 32'h44, pr: 1'b0, pidx: 6'h10, pf: 1'b0,
                           rpc: 32'h4, mc: m_miss});
    set_lk(1, 1, 0, 32'h40, 32'h10, 0);
    tick("uj_wins", model());
    set_lk(0, 1, 0, 32'hFFFF_FFF0, 32'h20, 0);
    tick("jal_wrap", model());
    set_lk(0, 0, 0, 32'hFFFF_FFFC, 0, 0);
    tick("seq_wrap", model());
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); s = nmq.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %p expected %p", s, o, e);
      end
    end
  endtask

  task automatic test_hazard();
    exp_t e, o;
    string s;
    idle();
    set_lk(1, 0, 0, 32'h1C, 32'h10, 0);
    set_upd(1, 7, 1, 1, 32'h1C, 32'h2C);
    tick("hazard_old", model());
    set_upd(0, 0, 0, 0, 0, 0);
    tick("hazard_new", model());
    set_upd(1, 7, 1, 1, 32'h1C, 32'h2C);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    expq.push_back('{tpc: 32'h20, pr: 1'b0, pidx: 6'd7, pf: 1'b0,
                     rpc: 32'h2C, mc: 32'd0});
    nmq.push_back("async_rst");
    obsq.push_back(obs);
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_upd(0, 0, 0, 0, 0, 0);
    tick("rst_cleared_cnt", '{tpc: 32'h20, pr: 1'b0, pidx: 6'd7, pf: 1'b0,
                              rpc: 32'h4, mc: 32'd0});
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); s = nmq.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %p expected %p", s, o, e);
      end
    end
  endtask

  task automatic test_gshare();
    exp_t e, o;
    string s;
    idle();
    set_upd(1, 3, 1, 1, 0, 32'h50);
    repeat (2) tick("gs_train", model());
    idle();
    set_lk(1, 0, 0, 32'h0, 32'h30, 0);
    tick("gs_lookup", '{tpc: 32'h30, pr: 1'b1, pidx: 6'd3, pf: 1'b0,
                        rpc: 32'h4, mc: 32'd0});
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); s = nmq.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %p expected %p", s, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef BP_GSHARE_EN
    test_gshare();
`else
    test_training();
    test_mispredict();
    test_jumps();
    test_hazard();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
